ysyx_22040931_bus_arbiter: RTL and testbench

Shares the single core memory port between instruction fetch and the load/store unit. Allows one outstanding transaction, routes each response to the requester that issued it, and drops fetch responses made stale by a pipeline flush. LSU has fixed priority; a starvation counter guarantees fetch forward progress. Sits between the IF stage and LSU on one side and the memory/bus bridge on the other.

---
 rtl/ysyx_22040931_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_ysyx_22040931_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040931_bus_arbiter.sv
// Arbitrates the single core memory port between instruction fetch and the LSU.
// One transaction in flight; LSU has priority, bounded by a fetch starvation counter.
module ysyx_22040931_bus_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4,
  localparam int MASK_W    = DATA_W / 8,
  localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  // fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store side
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  // debug visibility of the arbiter FSM
  output logic [1:0]        dbg_state,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  // Handshake: a request is accepted in the cycle where mem_req & mem_ready;
  // the owner's gnt pulses in that same cycle. Each accepted transaction is
  // answered by exactly one mem_rvalid cycle, routed back as a one-cycle rvalid.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cand_if, starve_hit, pick_ls, pick_if;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    if_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    ls_gnt     = 1'b0;
    ls_rvalid  = 1'b0;
    ls_rdata   = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    cand_if    = if_req & ~flush;
    starve_hit = cand_if && (cnt_q == CNT_MAX);
    pick_ls    = ls_req & ~starve_hit;
    pick_if    = cand_if & ~pick_ls;

    // Fetch that is not asking cannot be starving.
    if (!if_req) cnt_d = '0;

    // Outputs are forced quiet while reset is held.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (pick_ls) begin
            mem_req   = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_wmask = ls_wmask;
            if (mem_ready) begin
              ls_gnt  = 1'b1;
              state_d = BUSY_LS;
              if (cand_if && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (pick_if) begin
            mem_req  = 1'b1;
            mem_addr = if_addr;
            if (mem_ready) begin
              if_gnt  = 1'b1;
              state_d = BUSY_IF;
              cnt_d   = '0;
            end
          end
        end
        BUSY_IF: begin
          if (mem_rvalid) begin
            // A flush landing with the response still kills it.
            if (!flush) begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
            state_d = IDLE;
          end else if (flush) begin
            state_d = DROP;
          end
        end
        BUSY_LS: begin
          if (mem_rvalid) begin
            ls_rvalid = 1'b1;
            ls_rdata  = mem_rdata;
            state_d   = IDLE;
          end
        end
        DROP: begin
          if (mem_rvalid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign dbg_state      = reset ? IDLE : state_q;
  assign dbg_starve_cnt = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_ysyx_22040931_bus_arbiter.sv
// Directed bench for the bus arbiter: grant checks inline, responses checked
// by a monitor against an expected-response queue.
module tb_ysyx_22040931_bus_arbiter;

  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 4;
  localparam int MASK_W     = DATA_W / 8;
  localparam int CNT_W      = 3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_LS = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  logic              clock, reset, flush;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata, ls_rdata;
  logic [MASK_W-1:0] ls_wmask;
  logic              mem_req, mem_we, mem_ready, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [MASK_W-1:0] mem_wmask;
  logic [1:0]        dbg_state;
  logic [CNT_W-1:0]  dbg_starve_cnt;

  // {is_ls, data} of every response the DUT owes, in issue order.
  logic [DATA_W:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  ysyx_22040931_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // inputs change 1ns after the rising edge, outputs are sampled on the falling edge
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    flush = 0; if_req = 0; if_addr = '0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  function automatic logic any_output();
    return |{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_req, mem_we,
             mem_addr, mem_wdata, mem_wmask, dbg_state, dbg_starve_cnt};
  endfunction

  // scoreboard monitor
  always @(negedge clock) begin
    logic [DATA_W:0] e;
    if (if_rvalid || ls_rvalid) begin
      if (if_rvalid && ls_rvalid) check("dual_rvalid", 1, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: if_rvalid=%0b ls_rvalid=%0b, expected no response",
                 if_rvalid, ls_rvalid);
      end else begin
        e = exp_q.pop_front();
        check("rsp_owner_is_ls", 64'(ls_rvalid), 64'(e[DATA_W]));
        check("rsp_data", ls_rvalid ? ls_rdata : if_rdata, e[DATA_W-1:0]);
      end
    end
    if (!if_rvalid) check("if_rdata_idle_zero", if_rdata, 0);
    if (!ls_rvalid) check("ls_rdata_idle_zero", ls_rdata, 0);
  end

  initial begin
    int exp_cnt;
    logic exp_ls;

    // reset with requests asserted: everything must stay quiet
    idle_inputs();
    reset = 1; if_req = 1; ls_req = 1; mem_ready = 1;
    next_cycle();
    settle();
    check("reset_outputs_zero", 64'(any_output()), 0);
    next_cycle();
    reset = 0;
    idle_inputs();
    settle();
    check("post_reset_state", dbg_state, S_IDLE);
    check("post_reset_cnt", dbg_starve_cnt, 0);

    // single fetch
    next_cycle();
    if_req = 1; if_addr = 64'h8000_0000; mem_ready = 1;
    settle();
    check("fetch_if_gnt", if_gnt, 1);
    check("fetch_ls_gnt", ls_gnt, 0);
    check("fetch_mem_req", mem_req, 1);
    check("fetch_mem_addr", mem_addr, 64'h8000_0000);
    check("fetch_mem_we", mem_we, 0);
    exp_q.push_back({1'b0, 64'h13});
    next_cycle();
    if_req = 0; mem_rvalid = 1; mem_rdata = 64'h13;
    settle();
    check("fetch_busy_state", dbg_state, S_BUSY_IF);
    check("fetch_busy_no_req", mem_req, 0);
    next_cycle();
    idle_inputs();
    settle();
    check("fetch_back_idle", dbg_state, S_IDLE);

    // contention: LSU write wins, fetch waits for IDLE
    next_cycle();
    if_req = 1; if_addr = 64'h8000_0004;
    ls_req = 1; ls_we = 1; ls_addr = 64'h1000; ls_wdata = 64'hCAFE_F00D; ls_wmask = 8'hFF;
    mem_ready = 1;
    settle();
    check("cont_ls_gnt", ls_gnt, 1);
    check("cont_if_gnt", if_gnt, 0);
    check("cont_mem_we", mem_we, 1);
    check("cont_mem_addr", mem_addr, 64'h1000);
    check("cont_mem_wdata", mem_wdata, 64'hCAFE_F00D);
    check("cont_mem_wmask", mem_wmask, 8'hFF);
    exp_q.push_back({1'b1, 64'h0});
    next_cycle();
    ls_req = 0; ls_we = 0; mem_rvalid = 1; mem_rdata = 64'h0;
    settle();
    check("cont_busy_if_gnt", if_gnt, 0);
    check("cont_busy_mem_req", mem_req, 0);
    check("cont_cnt_one", dbg_starve_cnt, 1);
    next_cycle();
    mem_rvalid = 0;
    settle();
    check("cont_if_gnt_late", if_gnt, 1);
    check("cont_if_addr", mem_addr, 64'h8000_0004);
    check("cont_if_we", mem_we, 0);
    check("cont_if_wmask", mem_wmask, 0);
    check("cont_if_wdata", mem_wdata, 0);
    exp_q.push_back({1'b0, 64'hABCD});
    next_cycle();
    if_req = 0; mem_rvalid = 1; mem_rdata = 64'hABCD;
    settle();
    check("cont_cnt_cleared", dbg_starve_cnt, 0);
    next_cycle();
    idle_inputs();

    // starvation: LS,LS,LS,LS,IF repeating
    exp_cnt = 0;
    if_req = 1; if_addr = 64'h8000_0100;
    ls_req = 1; ls_we = 0; ls_addr = 64'h2000; mem_ready = 1;
    for (int i = 0; i < 10; i++) begin
      mem_rvalid = 0; mem_rdata = '0;
      settle();
      exp_ls = (i % 5) != 4;
      check("starve_ls_gnt", ls_gnt, 64'(exp_ls));
      check("starve_if_gnt", if_gnt, 64'(!exp_ls));
      exp_q.push_back({exp_ls, DATA_W'(256 + i)});
      exp_cnt = exp_ls ? ((exp_cnt < STARVE_MAX) ? exp_cnt + 1 : STARVE_MAX) : 0;
      next_cycle();
      mem_rvalid = 1; mem_rdata = DATA_W'(256 + i);
      settle();
      check("starve_cnt", dbg_starve_cnt, 64'(exp_cnt));
      next_cycle();
    end
    idle_inputs();

    // flush while fetch in flight: response dropped
    next_cycle();
    if_req = 1; if_addr = 64'h8000_0200; mem_ready = 1;
    settle();
    check("flush_if_gnt", if_gnt, 1);
    next_cycle();
    if_req = 0; flush = 1;
    settle();
    check("flush_state_busy", dbg_state, S_BUSY_IF);
    next_cycle();
    flush = 0;
    settle();
    check("flush_state_drop", dbg_state, S_DROP);
    next_cycle();
    mem_rvalid = 1; mem_rdata = 64'hDEAD;
    settle();
    check("flush_drop_no_rvalid", if_rvalid, 0);
    check("flush_drop_state", dbg_state, S_DROP);
    next_cycle();
    mem_rvalid = 0; mem_rdata = '0; if_req = 1; if_addr = 64'h8000_0204;
    settle();
    check("flush_after_idle", dbg_state, S_IDLE);
    check("flush_next_gnt", if_gnt, 1);
    exp_q.push_back({1'b0, 64'h55});
    next_cycle();
    if_req = 0; mem_rvalid = 1; mem_rdata = 64'h55;
    settle();
    next_cycle();
    idle_inputs();

    // flush coincident with the fetch response
    if_req = 1; if_addr = 64'h8000_0300; mem_ready = 1;
    settle();
    check("coinc_if_gnt", if_gnt, 1);
    next_cycle();
    if_req = 0; flush = 1; mem_rvalid = 1; mem_rdata = 64'h66;
    settle();
    check("coinc_no_rvalid", if_rvalid, 0);
    next_cycle();
    flush = 0; mem_rvalid = 0; mem_rdata = '0;
    settle();
    check("coinc_state_idle", dbg_state, S_IDLE);

    // flush in IDLE blocks fetch but not the LSU
    next_cycle();
    if_req = 1; flush = 1; mem_ready = 1;
    settle();
    check("idle_flush_if_gnt", if_gnt, 0);
    check("idle_flush_mem_req", mem_req, 0);
    next_cycle();
    ls_req = 1; ls_addr = 64'h3000;
    settle();
    check("idle_flush_ls_gnt", ls_gnt, 1);
    check("idle_flush_ls_addr", mem_addr, 64'h3000);
    exp_q.push_back({1'b1, 64'h77});
    next_cycle();
    ls_req = 0; if_req = 0; mem_rvalid = 1; mem_rdata = 64'h77;
    settle();
    next_cycle();
    idle_inputs();

    // back-pressure, then reset while the LSU read is in flight
    ls_req = 1; ls_addr = 64'h4000; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_mem_req", mem_req, 1);
      check("bp_no_gnt", ls_gnt, 0);
      check("bp_addr_stable", mem_addr, 64'h4000);
      next_cycle();
    end
    mem_ready = 1;
    settle();
    check("bp_ls_gnt", ls_gnt, 1);
    next_cycle();
    ls_req = 0; mem_ready = 0; reset = 1;
    settle();
    check("rst_busy_outputs_zero", 64'(any_output()), 0);
    next_cycle();
    reset = 0; mem_rvalid = 1; mem_rdata = 64'h99;
    settle();
    check("rst_state_idle", dbg_state, S_IDLE);
    check("rst_stale_rvalid_ignored", 64'(any_output()), 0);
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();

    check("exp_q_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
